// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, initiator state encoding and the
// request payload latched by a bus master.
package pci_pkg;

    localparam int unsigned AD_W  = 32;
    localparam int unsigned CBE_W = 4;

    localparam logic [CBE_W-1:0] PCI_CMD_READ       = 4'b0110;
    localparam logic [CBE_W-1:0] PCI_CMD_WRITE      = 4'b0111;
    localparam logic [CBE_W-1:0] PCI_CMD_MEM_RD_MUL = 4'b1100;
    localparam logic [CBE_W-1:0] PCI_CMD_MEM_RD_LN  = 4'b1110;
    localparam logic [CBE_W-1:0] PCI_CMD_MEM_WR_INV = 4'b1111;
    localparam logic [CBE_W-1:0] CBE_IDLE           = 4'b1111;

    localparam int unsigned DEVSEL_TIMEOUT_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ABORT,
        TURN
    } pci_state_e;

    typedef struct packed {
        logic             write;
        logic [AD_W-1:0]  addr;
        logic [CBE_W-1:0] be;
    } pci_req_t;

endpackage

// File: rtl/pci_initiator.sv
// PCI bus master: turns a local burst request into address/data phases,
// handling wait states, last-phase FRAME release, turnaround and master abort.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int unsigned      DEVSEL_TIMEOUT = DEVSEL_TIMEOUT_DEF,
    parameter logic [3:0]       CMD_READ       = PCI_CMD_READ,
    parameter logic [3:0]       CMD_WRITE      = PCI_CMD_WRITE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [3:0]  req_be,
    input  logic [31:0] wr_data,
    output logic        wr_data_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        abort,
    output logic        FRAME,
    inout  wire  [31:0] AD,
    output logic [3:0]  CBE,
    output logic        IRDY,
    input  logic        TRDY,
    input  logic        DEVSEL
);

    localparam int unsigned TMR_W = (DEVSEL_TIMEOUT < 2) ? 1 : $clog2(DEVSEL_TIMEOUT);
    localparam int unsigned REM_W = 5;

    pci_state_e         r_state, w_state_nxt;
    pci_req_t           r_req;
    logic [REM_W-1:0]   r_rem, w_rem_nxt;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic               r_dev_seen, w_dev_seen_nxt;
    logic               w_accept, w_xfer;

    logic               r_frame, w_frame_nxt;
    logic               r_irdy, w_irdy_nxt;
    logic [3:0]         r_cbe, w_cbe_nxt;
    logic               r_ad_oe, w_ad_oe_nxt;
    logic [31:0]        w_ad_out;

    logic [31:0]        r_rd_data;
    logic               r_rd_valid, r_done, r_abort, r_req_ready;

    assign w_accept = (r_state == IDLE) & req_valid;
    // Once DEVSEL has been claimed, a later deassertion no longer blocks transfers
    assign w_xfer   = (r_state == DATA) & ~TRDY & (r_dev_seen | ~DEVSEL);

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_tmr_nxt      = r_tmr;
        w_dev_seen_nxt = r_dev_seen;
        w_frame_nxt    = 1'b1;
        w_irdy_nxt     = 1'b1;
        w_cbe_nxt      = CBE_IDLE;
        w_ad_oe_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = ADDR;
                    w_rem_nxt      = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
                    w_tmr_nxt      = '0;
                    w_dev_seen_nxt = 1'b0;
                end
            end
            ADDR: w_state_nxt = DATA;
            DATA: begin
                if (!DEVSEL) begin
                    w_dev_seen_nxt = 1'b1;
                end else if (!r_dev_seen) begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
                if (w_xfer) begin
                    w_rem_nxt = r_rem - 5'd1;
                    if (r_rem == 5'd1) begin
                        w_state_nxt = TURN;
                    end
                end else if (!r_dev_seen && DEVSEL &&
                             r_tmr == TMR_W'(DEVSEL_TIMEOUT - 1)) begin
                    w_state_nxt = ABORT;
                end
            end
            ABORT:   w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Bus pins are registered from the state being entered
        case (w_state_nxt)
            ADDR: begin
                w_frame_nxt = 1'b0;
                w_cbe_nxt   = req_write ? CMD_WRITE : CMD_READ;
                w_ad_oe_nxt = 1'b1;
            end
            DATA: begin
                w_frame_nxt = (w_rem_nxt == 5'd1);
                w_irdy_nxt  = 1'b0;
                w_cbe_nxt   = r_req.be;
                w_ad_oe_nxt = r_req.write;
            end
            ABORT: begin
                w_irdy_nxt  = 1'b0;
                w_cbe_nxt   = r_req.be;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_rem       <= '0;
            r_tmr       <= '0;
            r_dev_seen  <= 1'b0;
            r_frame     <= 1'b1;
            r_irdy      <= 1'b1;
            r_cbe       <= CBE_IDLE;
            r_ad_oe     <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_tmr       <= w_tmr_nxt;
            r_dev_seen  <= w_dev_seen_nxt;
            r_frame     <= w_frame_nxt;
            r_irdy      <= w_irdy_nxt;
            r_cbe       <= w_cbe_nxt;
            r_ad_oe     <= w_ad_oe_nxt;
            if (w_accept) begin
                r_req <= '{write: req_write, addr: req_addr, be: req_be};
            end
            if (w_xfer && !r_req.write) begin
                r_rd_data <= AD;
            end
            r_rd_valid  <= w_xfer & ~r_req.write;
            r_done      <= (w_state_nxt == TURN) && (r_state == DATA);
            r_abort     <= (w_state_nxt == TURN) && (r_state == ABORT);
            r_req_ready <= (w_state_nxt == IDLE);
        end
    end

    // Write data comes straight from the local side so the ack edge advances it
    assign w_ad_out    = (r_state == ADDR) ? r_req.addr : wr_data;
    assign AD          = r_ad_oe ? w_ad_out : {32{1'bz}};
    assign wr_data_ack = w_xfer & r_req.write;

    assign FRAME     = r_frame;
    assign IRDY      = r_irdy;
    assign CBE       = r_cbe;
    assign req_ready = r_req_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign abort     = r_abort;

endmodule

// File: doc/pci_initiator.md
# pci_initiator

PCI bus master stage that sits directly upstream of the PCI target device on the shared bus. It accepts a burst request from the local side (command, address, length, byte enables) and drives FRAME, CBE, AD and IRDY. It responds to TRDY and DEVSEL, moving write words out or read words in. Wait states, the last-phase FRAME release, the turnaround cycle and master abort are all handled here.

## Interface
- DEVSEL_TIMEOUT, 5: data-phase cycles allowed without DEVSEL low before master abort.
- CMD_READ, 4'b0110: command driven on CBE for reads.
- CMD_WRITE, 4'b0111: command driven on CBE for writes.
- CLK  in  1  bus clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  local request present.
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid & req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  32  burst start address.
- req_len  in  4  word count; 1..15, with 0 meaning 16.
- req_be  in  4  active-low byte enables for every data phase.
- wr_data  in  32  current write word; must be stable until wr_data_ack.
- wr_data_ack  out  1  one-cycle pulse on each completed write transfer; the local side presents the next word on the following cycle.
- rd_data  out  32  registered read word.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- done  out  1  one-cycle pulse; the burst completed normally.
- abort  out  1  one-cycle pulse; master abort occurred (no DEVSEL).
- FRAME  out  1  active-low.
- AD  inout  32  address/data; tri-stated when not driven.
- CBE  out  4  command / byte enables.
- IRDY  out  1  active-low.
- TRDY  in  1  active-low.
- DEVSEL  in  1  active-low.

## Operation
- States: IDLE, ADDR, DATA, ABORT, TURN.
- IDLE
  - Outputs: FRAME=1, IRDY=1, CBE=4'b1111, AD hi-Z.
  - On accept: latch the request, set remaining = len, go to ADDR.
- ADDR (1 cycle)
  - Outputs: FRAME=0, IRDY=1, AD=addr, CBE=cmd.
  - Next state: DATA.
- DATA
  - Outputs: IRDY=0, CBE=be.
  - Write: AD=wr_data.
  - Read: AD released from the first DATA cycle onward (that cycle is the read turnaround).
  - FRAME=0 while remaining>1; FRAME=1 when remaining==1 (last data phase).
- Transfer condition: sampled IRDY=0 & TRDY=0 & DEVSEL=0 at a rising edge.
  - On transfer: decrement remaining and pulse wr_data_ack (write), or register AD into rd_data and pulse rd_valid next cycle (read).
  - The last transfer moves to TURN.
- Wait state (TRDY=1): hold AD, CBE, IRDY and FRAME unchanged; no ack/valid.
- DEVSEL timer
  - Counts DATA cycles with DEVSEL=1; it stops once DEVSEL is seen low.
  - On reaching DEVSEL_TIMEOUT: go to ABORT.
- ABORT (1 cycle): FRAME=1, IRDY=0, AD hi-Z; then TURN with the abort flag set.
- TURN (1 cycle)
  - Outputs: FRAME=1, IRDY=1, AD hi-Z, CBE=4'b1111.
  - Pulse done, or abort if the flag is set; then IDLE.
- DEVSEL dropping after being asserted mid-burst is ignored; only TRDY gates transfers.
- A req_valid arriving outside IDLE is not accepted.

## Timing
- Reset (async) forces, immediately and mid-burst:
  - state=IDLE, FRAME=1, IRDY=1, CBE=4'b1111, AD hi-Z.
  - req_ready=1 after release.
  - rd_data=0; all pulses (rd_valid, wr_data_ack, done, abort) 0.
- Bus occupancy: accept edge → ADDR next cycle → first DATA the following cycle.
- Zero-wait burst of N: N DATA cycles + 1 TURN. Back-to-back requests leave at least one IDLE cycle after TURN.
- rd_valid follows its transfer edge by 1 cycle. wr_data_ack is asserted in the transfer cycle (combinational with the sampled edge, registered for use next cycle).
- len=1: FRAME is high in the same cycle IRDY first goes low.
- Timeout with no DEVSEL: abort pulse 1+DEVSEL_TIMEOUT+2 cycles after ADDR.

## Structure
- Shared package pci_pkg holds:
  - command codes (CMD_READ/CMD_WRITE defaults, plus memory read/write encodings for future masters);
  - the state encoding;
  - the 4'b1111 idle CBE constant.
- The device and the initiator both use pci_pkg.
- No sub-module required. The remaining/timeout counters and the AD output-enable live inline; AD is driven via assign with an internal ad_oe, in the same style as the bus benches.

## Test plan
- Write len=4, addr 32'hffff_0005, words f0f0..f0f3, target TRDY=0 from the first data phase → 4 wr_data_ack pulses, FRAME high in the 4th DATA cycle, done 1 cycle later.
- Same write with TRDY=1 for 1 cycle at the 3rd word → AD holds 32'h0000_f0f2 for 2 cycles, exactly 4 acks, done delayed by 1.
- Read len=2 at 32'hffff_0004, target returns 32'h0000_f0f0, 32'h0000_f0f1 → AD hi-Z from the first DATA cycle, rd_valid twice with those values, done.
- DEVSEL held 1 → after 5 DATA cycles, ABORT (FRAME=1, IRDY=0) then TURN, abort pulse, no done, no acks.
- len=0 → 16 transfers; len=1 → FRAME=1 and IRDY=0 together in the single DATA cycle.
- RST asserted in the middle of a write burst → FRAME=1, IRDY=1, AD hi-Z asynchronously; after release req_ready=1 and a new read completes normally.
